pat_chk: RTL and testbench

- Downstream checker for the counting pattern generator in the common test fabric.
- Samples the generator's count bus when qualified by a valid strobe and predicts the next value of the 0..LIM wrap sequence.
- Acquires lock, then flags, counts and tracks sequence errors, including injected ones.
- Sits between the pattern source (possibly through the TMR path under test) and the status/readout logic.

---
 rtl/pat_chk_if.sv | 28 ++
 rtl/pat_chk.sv | 136 +++++++++++++
 tb/tb_pat_chk.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pat_chk_if.sv
// Checker-side bus for pat_chk: sample strobe, count data, clear and status outputs.
// Build option PAT_CHK_CAPTURE_EN adds the last_exp_o / last_got_o capture outputs.
interface pat_chk_if #(
  parameter int IO_SIZE_G = 4,
  parameter int CNT_W     = 16
);
  logic                 vld_i;
  logic [IO_SIZE_G-1:0] data_i;
  logic                 clr_i;
  logic                 locked_o;
  logic                 err_o;
  logic [CNT_W-1:0]     err_cnt_o;
  logic                 err_sticky_o;
`ifdef PAT_CHK_CAPTURE_EN
  logic [IO_SIZE_G-1:0] last_exp_o;
  logic [IO_SIZE_G-1:0] last_got_o;

  modport master (output vld_i, data_i, clr_i,
                  input  locked_o, err_o, err_cnt_o, err_sticky_o, last_exp_o, last_got_o);
  modport slave  (input  vld_i, data_i, clr_i,
                  output locked_o, err_o, err_cnt_o, err_sticky_o, last_exp_o, last_got_o);
`else
  modport master (output vld_i, data_i, clr_i,
                  input  locked_o, err_o, err_cnt_o, err_sticky_o);
  modport slave  (input  vld_i, data_i, clr_i,
                  output locked_o, err_o, err_cnt_o, err_sticky_o);
`endif
endinterface

// File: rtl/pat_chk.sv
// Checker for the 0..LIM wrapping count pattern: acquires lock, then counts sequence errors.
// Build option PAT_CHK_CAPTURE_EN adds capture of expected/received values on each counted error.
module pat_chk #(
  parameter int IO_SIZE_G = 4,
  parameter int LIM       = 14,
  parameter int LOCK_CNT  = 4,
  parameter int MISS_MAX  = 3,
  parameter int CNT_W     = 16
) (
  input  logic    clk_i,
  input  logic    rst_i,
  pat_chk_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam int SW = (MISS_MAX > 1) ? $clog2(MISS_MAX + 1) : 1;

  localparam logic [IO_SIZE_G-1:0] LIM_V      = IO_SIZE_G'(LIM);
  localparam logic [MW-1:0]        LOCK_LAST  = MW'(LOCK_CNT - 1);
  localparam logic [SW-1:0]        MISS_LAST  = SW'(MISS_MAX - 1);
  localparam logic [CNT_W-1:0]     CNT_SAT    = '1;

  logic [1:0]           state_q, state_d;
  logic [IO_SIZE_G-1:0] exp_q, exp_nxt;
  logic [MW-1:0]        match_q, match_d;
  logic [SW-1:0]        miss_q, miss_d;
  logic                 locked_q, err_q, sticky_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 hit, err_ev;

  // Values above LIM can never be part of the sequence, and restart it at 0.
  assign hit     = (bus.data_i <= LIM_V) && (bus.data_i == exp_q);
  assign exp_nxt = (bus.data_i >= LIM_V) ? '0 : bus.data_i + IO_SIZE_G'(1);
  assign err_ev  = bus.vld_i && (state_q == ST_LOCKED) && !hit;

  // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    miss_d  = miss_q;
    if (bus.vld_i) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQ;
          match_d = '0;
        end
        ST_ACQ: begin
          if (!hit) begin
            match_d = '0;
          end else if (match_q == LOCK_LAST) begin
            state_d = ST_LOCKED;
            miss_d  = '0;
          end else begin
            match_d = match_q + MW'(1);
          end
        end
        ST_LOCKED: begin
          if (hit) begin
            miss_d = '0;
          end else if (miss_q == MISS_LAST) begin
            state_d = ST_ACQ;
            match_d = '0;
            miss_d  = '0;
          end else begin
            miss_d = miss_q + SW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      exp_q    <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= (state_d == ST_LOCKED);
      err_q    <= err_ev;
      // Prediction always follows received data so one bad sample costs one error.
      if (bus.vld_i) exp_q <= exp_nxt;
    end
  end

  // A clear coincident with an error keeps that error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else if (bus.clr_i) begin
      cnt_q    <= err_ev ? CNT_W'(1) : '0;
      sticky_q <= err_ev;
    end else if (err_ev) begin
      sticky_q <= 1'b1;
      if (cnt_q != CNT_SAT) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.locked_o     = locked_q;
  assign bus.err_o        = err_q;
  assign bus.err_cnt_o    = cnt_q;
  assign bus.err_sticky_o = sticky_q;

`ifdef PAT_CHK_CAPTURE_EN
  logic [IO_SIZE_G-1:0] last_exp_q, last_got_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_exp_q <= '0;
      last_got_q <= '0;
    end else if (err_ev) begin
      last_exp_q <= exp_q;
      last_got_q <= bus.data_i;
    end else if (bus.clr_i) begin
      last_exp_q <= '0;
      last_got_q <= '0;
    end
  end

  assign bus.last_exp_o = last_exp_q;
  assign bus.last_got_o = last_got_q;
`endif

endmodule

// File: tb/tb_pat_chk.sv
// Randomised and directed bench for pat_chk against a sample-level reference model.
module tb_pat_chk;
  localparam int IO    = 4;
  localparam int LIM   = 14;
  localparam int LOCK  = 4;
  localparam int MISS  = 3;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  pat_chk_if #(.IO_SIZE_G(IO), .CNT_W(CW)) bus ();

  pat_chk #(.IO_SIZE_G(IO), .LIM(LIM), .LOCK_CNT(LOCK), .MISS_MAX(MISS), .CNT_W(CW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: mode 0 idle, 1 acquiring, 2 locked.
  int m_mode, m_exp, m_run, m_miss, m_cnt;
  bit m_sticky, m_err, m_locked;
  int m_lexp, m_lgot;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int seq_next(input int x);
    return (x >= LIM) ? 0 : x + 1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_exp = 0; m_run = 0; m_miss = 0; m_cnt = 0;
    m_sticky = 0; m_err = 0; m_locked = 0; m_lexp = 0; m_lgot = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit c);
    bit counted = 0;
    bit good;
    if (v) begin
      good = (d <= LIM) && (d == m_exp);
      if (m_mode == 0) begin
        m_mode = 1; m_run = 0;
      end else if (m_mode == 1) begin
        m_run = good ? m_run + 1 : 0;
        if (m_run == LOCK) begin m_mode = 2; m_miss = 0; end
      end else begin
        if (good) m_miss = 0;
        else begin
          counted = 1;
          m_miss++;
          if (m_miss == MISS) begin m_mode = 1; m_run = 0; m_miss = 0; end
        end
      end
      if (counted) begin m_lexp = m_exp; m_lgot = d; end
      m_exp = seq_next(d);
    end
    if (!counted && c) begin m_lexp = 0; m_lgot = 0; end
    m_err = counted;
    m_locked = (m_mode == 2);
    if (c) begin
      m_cnt = counted ? 1 : 0;
      m_sticky = counted;
    end else if (counted) begin
      m_sticky = 1;
      if (m_cnt < CMAX) m_cnt++;
    end
  endtask

  task automatic compare_all();
    check("locked", 32'(bus.locked_o), 32'(m_locked));
    check("err",    32'(bus.err_o), 32'(m_err));
    check("cnt",    32'(bus.err_cnt_o), 32'(m_cnt));
    check("sticky", 32'(bus.err_sticky_o), 32'(m_sticky));
`ifdef PAT_CHK_CAPTURE_EN
    check("last_exp", 32'(bus.last_exp_o), 32'(m_lexp));
    check("last_got", 32'(bus.last_got_o), 32'(m_lgot));
`endif
  endtask

  task automatic send(input bit v, input int d, input bit c);
    bus.vld_i  = v;
    bus.data_i = IO'(d);
    bus.clr_i  = c;
    @(posedge clk_i);
    model_step(v, d, c);
    #1;
    compare_all();
  endtask

  function automatic int wrong_value();
    int w;
    do w = $urandom_range(0, (1 << IO) - 1); while (w == m_exp);
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq;
    model_reset();
    bus.vld_i = 0; bus.data_i = '0; bus.clr_i = 0;
    #12;
    check("rst_locked", 32'(bus.locked_o), 0);
    check("rst_cnt",    32'(bus.err_cnt_o), 0);
    check("rst_sticky", 32'(bus.err_sticky_o), 0);
    rst_i = 0;
    #10;

    // Clean counting sequence with wraps.
    seq = 0;
    for (int i = 1; i <= 40; i++) begin
      send(1, seq, 0);
      if (i == 4) check("lock_early", 32'(bus.locked_o), 0);
      if (i == 5) check("lock_5th",   32'(bus.locked_o), 1);
      seq = seq_next(seq);
    end
    check("clean_cnt", 32'(bus.err_cnt_o), 0);

    // Injected 15 where 6 is expected.
    while (m_exp != 6) send(1, m_exp, 0);
    send(1, 15, 0);
    check("inj_err",    32'(bus.err_o), 1);
    check("inj_cnt",    32'(bus.err_cnt_o), 1);
    check("inj_sticky", 32'(bus.err_sticky_o), 1);
    check("inj_locked", 32'(bus.locked_o), 1);
`ifdef PAT_CHK_CAPTURE_EN
    check("inj_lexp", 32'(bus.last_exp_o), 6);
    check("inj_lgot", 32'(bus.last_got_o), 15);
`endif
    send(1, 0, 0);
    check("inj_single", 32'(bus.err_o), 0);
    send(1, 1, 0);

    // Clear alone, then stuck data forces loss of lock.
    send(0, 3, 1);
    check("clr_cnt",    32'(bus.err_cnt_o), 0);
    check("clr_sticky", 32'(bus.err_sticky_o), 0);
    while (m_exp != 7) send(1, m_exp, 0);
    for (int i = 0; i < 4; i++) send(1, 7, 0);
    check("stuck_cnt",    32'(bus.err_cnt_o), 3);
    check("stuck_unlock", 32'(bus.locked_o), 0);
    for (int d = 8; d <= 12; d++) begin
      send(1, d, 0);
      if (d == 10) check("relock_early", 32'(bus.locked_o), 0);
      if (d == 11) check("relock",       32'(bus.locked_o), 1);
    end
    check("relock_cnt", 32'(bus.err_cnt_o), 3);

    // Gaps with random data are ignored.
    for (int i = 0; i < 3; i++) send(0, $urandom_range(0, 15), 0);
    send(1, m_exp, 0);
    check("gap_err",    32'(bus.err_o), 0);
    check("gap_locked", 32'(bus.locked_o), 1);
    check("gap_cnt",    32'(bus.err_cnt_o), 3);

    // Saturation, then clear coincident with an error.
    for (int i = 0; i < 20; i++) begin
      send(1, wrong_value(), 0);
      send(1, m_exp, 0);
    end
    check("sat_cnt", 32'(bus.err_cnt_o), CMAX);
    send(1, wrong_value(), 1);
    check("clr_err_cnt",    32'(bus.err_cnt_o), 1);
    check("clr_err_sticky", 32'(bus.err_sticky_o), 1);
    check("clr_err_pulse",  32'(bus.err_o), 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit v, c;
      int d;
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 4) != 0) ? m_exp : $urandom_range(0, 15);
      c = ($urandom_range(0, 15) == 0);
      send(v, d, c);
    end

    // Build err_cnt_o=5 while locked, then reset between edges.
    send(0, 0, 1);
    for (int i = 0; i < 8; i++) send(1, m_exp, 0);
    check("pre_rst_locked", 32'(bus.locked_o), 1);
    for (int i = 0; i < 5; i++) begin
      send(1, wrong_value(), 0);
      send(1, m_exp, 0);
    end
    check("pre_rst_cnt", 32'(bus.err_cnt_o), 5);
    #3;
    rst_i = 1;
    bus.vld_i = 0;
    #1;
    model_reset();
    check("arst_locked", 32'(bus.locked_o), 0);
    check("arst_err",    32'(bus.err_o), 0);
    check("arst_cnt",    32'(bus.err_cnt_o), 0);
    check("arst_sticky", 32'(bus.err_sticky_o), 0);
    @(posedge clk_i);
    #2;
    rst_i = 0;
    for (int d = 3; d <= 7; d++) begin
      send(1, d, 0);
      if (d == 6) check("post_rst_early", 32'(bus.locked_o), 0);
      if (d == 7) check("post_rst_lock",  32'(bus.locked_o), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
